// File: rtl/mix_col_if.sv
// Stream interface for the MixColumns pipeline: an upstream beat channel,
// a downstream result channel and the completed-beat counter.
interface mix_col_if #(
  parameter int NCOL  = 4,
  parameter int CNT_W = 16
);
  logic                  InValid;
  logic                  InReady;
  logic [32*NCOL-1:0]    DataIn;
  logic                  Inv;
  logic                  Bypass;
  logic                  OutValid;
  logic                  OutReady;
  logic [32*NCOL-1:0]    DataOut;
  logic [CNT_W-1:0]      BeatCount;

  modport slave (
    input  InValid, DataIn, Inv, Bypass, OutReady,
    output InReady, OutValid, DataOut, BeatCount
  );

  modport master (
    output InValid, DataIn, Inv, Bypass, OutReady,
    input  InReady, OutValid, DataOut, BeatCount
  );
endinterface

// File: rtl/mix_col_pipe.sv
// Two-stage AES MixColumns / InvMixColumns pipeline with per-beat mode,
// bypass for the final round, valid/ready backpressure and a saturating beat counter.
module mix_col_pipe #(
  parameter int NCOL  = 4,
  parameter int CNT_W = 16
) (
  input  logic      Clk,
  input  logic      Rst,
  mix_col_if.slave  bus
);

  localparam int NB = 4 * NCOL;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // tv packs {x^3 b, x^2 b, x b, b}; each coefficient bit picks one term.
  function automatic logic [7:0] gf_mul(input logic [31:0] tv, input logic [3:0] k);
    return ({8{k[0]}} & tv[7:0])   ^ ({8{k[1]}} & tv[15:8]) ^
           ({8{k[2]}} & tv[23:16]) ^ ({8{k[3]}} & tv[31:24]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                    vld_p1_q;
  logic                    inv_p1_q;
  logic                    byp_p1_q;
  logic [NB-1:0][31:0]     terms_p1_q;
  logic [NB-1:0][31:0]     terms_p1_d;

  logic                    vld_p2_q;
  logic [32*NCOL-1:0]      data_p2_q;
  logic [0:NB-1][7:0]      data_p2_d;

  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;

  logic [0:NB-1][7:0]      din_b;
  logic                    stall;
  logic                    in_rdy;
  logic                    in_xfer;
  logic                    out_vld;
  logic                    out_xfer;

  assign stall    = vld_p2_q && !bus.OutReady;
  assign in_rdy   = !stall && !Rst;
  assign in_xfer  = bus.InValid && in_rdy;
  assign out_vld  = vld_p2_q && !Rst;
  assign out_xfer = out_vld && bus.OutReady;
  assign cnt_d    = out_xfer ? sat_inc(cnt_q) : cnt_q;

  // Byte 0 is s0 of column 0, i.e. the MSB of the bus.
  assign din_b = bus.DataIn;

  for (genvar n = 0; n < NB; n++) begin : g_byte
    localparam int BASE = 4 * (n / 4);
    localparam int R    = n % 4;
    localparam int I0   = BASE + R;
    localparam int I1   = BASE + (R + 1) % 4;
    localparam int I2   = BASE + (R + 2) % 4;
    localparam int I3   = BASE + (R + 3) % 4;

    logic [7:0] x2, x4, x8;
    logic [7:0] fwd, inv;

    assign x2 = xtime(din_b[n]);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);
    assign terms_p1_d[n] = {x8, x4, x2, din_b[n]};

    // Row r uses the circulant coefficients rotated by r within its column.
    assign fwd = gf_mul(terms_p1_q[I0], 4'h2) ^ gf_mul(terms_p1_q[I1], 4'h3) ^
                 gf_mul(terms_p1_q[I2], 4'h1) ^ gf_mul(terms_p1_q[I3], 4'h1);
    assign inv = gf_mul(terms_p1_q[I0], 4'hE) ^ gf_mul(terms_p1_q[I1], 4'hB) ^
                 gf_mul(terms_p1_q[I2], 4'hD) ^ gf_mul(terms_p1_q[I3], 4'h9);

    assign data_p2_d[n] = byp_p1_q ? terms_p1_q[n][7:0] : (inv_p1_q ? inv : fwd);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_p1_q   <= 1'b0;
      inv_p1_q   <= 1'b0;
      byp_p1_q   <= 1'b0;
      terms_p1_q <= '0;
      vld_p2_q   <= 1'b0;
      data_p2_q  <= '0;
      cnt_q      <= '0;
    end else begin
      if (!stall) begin
        // ---- stage p1: capture byte and its xtime powers ----
        vld_p1_q <= in_xfer;
        if (in_xfer) begin
          inv_p1_q   <= bus.Inv;
          byp_p1_q   <= bus.Bypass;
          terms_p1_q <= terms_p1_d;
        end
        // ---- stage p2: XOR-combine into the selected mode result ----
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          data_p2_q <= data_p2_d;
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.InReady   = in_rdy;
  assign bus.OutValid  = out_vld;
  assign bus.DataOut   = Rst ? '0 : data_p2_q;
  assign bus.BeatCount = cnt_q;

endmodule

// File: tb/tb_mix_col_pipe.sv
// Directed bench for mix_col_pipe: a 1-column instance with a 16-bit counter
// and a 4-column instance with a 4-bit counter share clock and reset.
module tb_mix_col_pipe;

  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  mix_col_if #(.NCOL(1), .CNT_W(16)) ifa ();
  mix_col_if #(.NCOL(4), .CNT_W(4))  ifb ();

  mix_col_pipe #(.NCOL(1), .CNT_W(16)) dut_a (.Clk(Clk), .Rst(Rst), .bus(ifa));
  mix_col_pipe #(.NCOL(4), .CNT_W(4))  dut_b (.Clk(Clk), .Rst(Rst), .bus(ifb));

  always #5 Clk = ~Clk;

  localparam logic [127:0] VEC_PLAIN = 128'hDB135345_F20A225C_01010101_C6C6C6C6;
  localparam logic [127:0] VEC_MIXED = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;
  localparam logic [127:0] VEC_P2    = 128'hD4D4D4D5_2D26314C_01010101_DB135345;
  localparam logic [127:0] VEC_M2    = 128'hD5D5D7D6_4D7EBDF8_01010101_8E4DA1BC;
  localparam logic [127:0] VEC_RAW1  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] VEC_RAW2  = 128'hDEADBEEF_CAFEF00D_00000000_FFFFFFFF;

  task automatic idle_a();
    ifa.InValid = 1'b0;
    ifa.DataIn  = $urandom;
    ifa.Inv     = 1'($urandom_range(1));
    ifa.Bypass  = 1'($urandom_range(1));
  endtask

  task automatic idle_b();
    ifb.InValid = 1'b0;
    ifb.DataIn  = {$urandom, $urandom, $urandom, $urandom};
    ifb.Inv     = 1'($urandom_range(1));
    ifb.Bypass  = 1'($urandom_range(1));
  endtask

  task automatic drive_b(input logic [127:0] d, input logic inv, input logic byp);
    ifb.InValid = 1'b1;
    ifb.DataIn  = d;
    ifb.Inv     = inv;
    ifb.Bypass  = byp;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    ifa.InValid = 1'b1; ifa.DataIn = 32'h12345678; ifa.Inv = 1'b0; ifa.Bypass = 1'b0;
    ifb.InValid = 1'b1; ifb.DataIn = VEC_PLAIN;    ifb.Inv = 1'b0; ifb.Bypass = 1'b0;
    ifa.OutReady = 1'b1;
    ifb.OutReady = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    checks++; if (ifa.InReady !== 1'b0) begin errors++; $display("FAIL rst_inready_a got %b want 0", ifa.InReady); end
    checks++; if (ifb.InReady !== 1'b0) begin errors++; $display("FAIL rst_inready_b got %b want 0", ifb.InReady); end
    checks++; if (ifb.OutValid !== 1'b0) begin errors++; $display("FAIL rst_outvalid_b got %b want 0", ifb.OutValid); end
    checks++; if (ifb.DataOut !== 128'h0) begin errors++; $display("FAIL rst_dataout_b got %h want 0", ifb.DataOut); end
    checks++; if (ifa.BeatCount !== 16'h0) begin errors++; $display("FAIL rst_count_a got %h want 0", ifa.BeatCount); end
    checks++; if (ifb.BeatCount !== 4'h0) begin errors++; $display("FAIL rst_count_b got %h want 0", ifb.BeatCount); end
    @(negedge Clk);
    Rst = 1'b0;
    idle_a();
    idle_b();
    #1;
    checks++; if (ifa.InReady !== 1'b1) begin errors++; $display("FAIL post_rst_inready_a got %b want 1", ifa.InReady); end
    checks++; if (ifb.InReady !== 1'b1) begin errors++; $display("FAIL post_rst_inready_b got %b want 1", ifb.InReady); end
    checks++; if (ifb.OutValid !== 1'b0) begin errors++; $display("FAIL post_rst_outvalid_b got %b want 0", ifb.OutValid); end
  endtask

  task automatic test_forward();
    @(negedge Clk);
    ifa.InValid = 1'b1; ifa.DataIn = 32'hDB135345; ifa.Inv = 1'b0; ifa.Bypass = 1'b0;
    ifa.OutReady = 1'b1;
    #1;
    checks++; if (ifa.InReady !== 1'b1) begin errors++; $display("FAIL fwd_inready got %b want 1", ifa.InReady); end
    @(negedge Clk);
    idle_a();
    #1;
    checks++; if (ifa.OutValid !== 1'b0) begin errors++; $display("FAIL fwd_lat1_valid got %b want 0", ifa.OutValid); end
    @(negedge Clk);
    #1;
    checks++; if (ifa.OutValid !== 1'b1) begin errors++; $display("FAIL fwd_lat2_valid got %b want 1", ifa.OutValid); end
    checks++; if (ifa.DataOut !== 32'h8E4DA1BC) begin errors++; $display("FAIL fwd_data got %h want 8e4da1bc", ifa.DataOut); end
    @(negedge Clk);
    #1;
    checks++; if (ifa.OutValid !== 1'b0) begin errors++; $display("FAIL fwd_drain_valid got %b want 0", ifa.OutValid); end
    checks++; if (ifa.BeatCount !== 16'd1) begin errors++; $display("FAIL fwd_count got %0d want 1", ifa.BeatCount); end
  endtask

  task automatic test_inverse();
    @(negedge Clk);
    drive_b(VEC_MIXED, 1'b1, 1'b0);
    ifb.OutReady = 1'b1;
    @(negedge Clk);
    idle_b();
    #1;
    checks++; if (ifb.OutValid !== 1'b0) begin errors++; $display("FAIL inv_lat1_valid got %b want 0", ifb.OutValid); end
    @(negedge Clk);
    #1;
    checks++; if (ifb.OutValid !== 1'b1) begin errors++; $display("FAIL inv_lat2_valid got %b want 1", ifb.OutValid); end
    checks++; if (ifb.DataOut !== VEC_PLAIN) begin errors++; $display("FAIL inv_data got %h want %h", ifb.DataOut, VEC_PLAIN); end
    @(negedge Clk);
    #1;
    checks++; if (ifb.BeatCount !== 4'd1) begin errors++; $display("FAIL inv_count got %0d want 1", ifb.BeatCount); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] din [5];
    logic [127:0] exp [5];
    logic         inv [5];
    logic         byp [5];
    din[0] = VEC_PLAIN; inv[0] = 1'b0; byp[0] = 1'b0; exp[0] = VEC_MIXED;
    din[1] = VEC_MIXED; inv[1] = 1'b1; byp[1] = 1'b0; exp[1] = VEC_PLAIN;
    din[2] = VEC_RAW1;  inv[2] = 1'b1; byp[2] = 1'b1; exp[2] = VEC_RAW1;
    din[3] = VEC_P2;    inv[3] = 1'b0; byp[3] = 1'b0; exp[3] = VEC_M2;
    din[4] = VEC_RAW2;  inv[4] = 1'b0; byp[4] = 1'b1; exp[4] = VEC_RAW2;
    ifb.OutReady = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge Clk);
      if (j < 5) drive_b(din[j], inv[j], byp[j]);
      else idle_b();
      #1;
      if (j < 5) begin
        checks++; if (ifb.InReady !== 1'b1) begin errors++; $display("FAIL b2b_inready[%0d] got %b want 1", j, ifb.InReady); end
      end
      checks++;
      if (ifb.OutValid !== (j >= 2 && j < 7)) begin
        errors++; $display("FAIL b2b_valid[%0d] got %b want %b", j, ifb.OutValid, (j >= 2 && j < 7));
      end
      if (j >= 2 && j < 7) begin
        checks++; if (ifb.DataOut !== exp[j-2]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", j-2, ifb.DataOut, exp[j-2]); end
      end
    end
    checks++; if (ifb.BeatCount !== 4'd6) begin errors++; $display("FAIL b2b_count got %0d want 6", ifb.BeatCount); end
  endtask

  task automatic test_backpressure();
    logic [127:0] want;
    for (int j = 0; j < 9; j++) begin
      @(negedge Clk);
      case (j)
        0: begin ifb.OutReady = 1'b0; drive_b(VEC_PLAIN, 1'b0, 1'b0); end
        1: drive_b(VEC_MIXED, 1'b1, 1'b0);
        2, 3, 4: drive_b(VEC_RAW1, 1'b0, 1'b1);
        5: begin ifb.OutReady = 1'b1; drive_b(VEC_RAW1, 1'b0, 1'b1); end
        default: idle_b();
      endcase
      #1;
      if (j <= 1 || j == 5) begin
        checks++; if (ifb.InReady !== 1'b1) begin errors++; $display("FAIL bp_inready[%0d] got %b want 1", j, ifb.InReady); end
      end
      if (j >= 2 && j <= 4) begin
        checks++; if (ifb.InReady !== 1'b0) begin errors++; $display("FAIL bp_inready[%0d] got %b want 0", j, ifb.InReady); end
      end
      if (j >= 2 && j <= 7) begin
        want = (j <= 5) ? VEC_MIXED : (j == 6) ? VEC_PLAIN : VEC_RAW1;
        checks++; if (ifb.OutValid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", j, ifb.OutValid); end
        checks++; if (ifb.DataOut !== want) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", j, ifb.DataOut, want); end
      end
      if (j == 8) begin
        checks++; if (ifb.OutValid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %b want 0", ifb.OutValid); end
        checks++; if (ifb.BeatCount !== 4'd9) begin errors++; $display("FAIL bp_count got %0d want 9", ifb.BeatCount); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 8; j++) begin
      @(negedge Clk);
      case (j)
        0: begin ifb.OutReady = 1'b0; drive_b(VEC_PLAIN, 1'b0, 1'b0); end
        1: drive_b(VEC_MIXED, 1'b1, 1'b0);
        2: begin Rst = 1'b1; drive_b(VEC_RAW2, 1'b0, 1'b1); end
        3: begin Rst = 1'b0; ifb.OutReady = 1'b1; idle_b(); end
        default: idle_b();
      endcase
      #1;
      if (j == 2) begin
        checks++; if (ifb.OutValid !== 1'b0) begin errors++; $display("FAIL rmid_valid_in_rst got %b want 0", ifb.OutValid); end
        checks++; if (ifb.DataOut !== 128'h0) begin errors++; $display("FAIL rmid_data_in_rst got %h want 0", ifb.DataOut); end
        checks++; if (ifb.InReady !== 1'b0) begin errors++; $display("FAIL rmid_inready_in_rst got %b want 0", ifb.InReady); end
      end
      if (j == 3) begin
        checks++; if (ifb.BeatCount !== 4'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", ifb.BeatCount); end
        checks++; if (ifb.InReady !== 1'b1) begin errors++; $display("FAIL rmid_inready got %b want 1", ifb.InReady); end
      end
      if (j >= 3) begin
        checks++; if (ifb.OutValid !== 1'b0) begin errors++; $display("FAIL rmid_stale[%0d] got %b want 0", j, ifb.OutValid); end
      end
    end
  endtask

  task automatic test_saturation();
    int e;
    ifb.OutReady = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(negedge Clk);
      if (j < 20) drive_b({4{32'(j)}}, 1'b0, 1'b1);
      else idle_b();
      #1;
      e = j - 2;
      if (e < 0) e = 0;
      if (e > 15) e = 15;
      checks++; if (ifb.BeatCount !== 4'(e)) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", j, ifb.BeatCount, e); end
      if (j >= 2 && j < 22) begin
        checks++; if (ifb.DataOut !== {4{32'(j-2)}}) begin errors++; $display("FAIL sat_data[%0d] got %h want %h", j-2, ifb.DataOut, {4{32'(j-2)}}); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
